phase_sequencer: RTL

- Timing-beat controller for the multi-cycle 16-bit RISC core.
- Generates the one-hot phase strobes T0..T(N-1) that gate Fetch (T0/T1), decode, execute and writeback.
- Handles start, halt (external request or HALT opcode) and memory stall.
- Counts retired instructions.

---
 rtl/phase_sequencer.sv | 102 ++++++++++
 1 files changed

// File: rtl/phase_sequencer.sv
// phase_sequencer: one-hot phase strobe generator with start/halt/stall control and retired-instruction count (SINGLE_STEP_EN adds a step/pause mode)
module phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int OPC_W = 5,
  parameter logic [OPC_W-1:0] HALT_OPC = 5'b11111,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  stall,
  input  logic [OPC_W-1:0]      opcode,
  output logic [NUM_PHASES-1:0] T,
  output logic                  running,
  output logic                  halted,
  output logic                  instr_done,
  output logic [CNT_W-1:0]      instr_cnt
`ifdef SINGLE_STEP_EN
  ,
  input  logic                  step_mode,
  input  logic                  step
`endif
);
  localparam int PW = (NUM_PHASES > 2) ? $clog2(NUM_PHASES) : 1;
  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
`ifdef SINGLE_STEP_EN
    , PAUSE
`endif
  } state_t;
  state_t state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic halt_pend_q, halt_pend_d;
  logic last;
  assign last = phase_q == PW'(NUM_PHASES - 1);
  assign T = (state_q == RUN) ? NUM_PHASES'(1) << phase_q : '0;
  assign running = state_q == RUN;
  assign halted = state_q == HALT;
  assign instr_cnt = instr_cnt_q;
  // State register; reset drops everything immediately, even mid-instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      instr_cnt_q <= '0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      instr_cnt_q <= instr_cnt_d;
      halt_pend_q <= halt_pend_d;
    end
  end
  // Next-state logic: phases advance unless stalled; the final phase is the instruction boundary
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    instr_cnt_d = instr_cnt_q;
    halt_pend_d = halt_pend_q;
    instr_done = (state_q == RUN) && last && !stall;
    case (state_q)
      IDLE, HALT: begin
        if (start) begin
          state_d = RUN;
          phase_d = '0;
        end
      end
      RUN: begin
        if (halt_req) halt_pend_d = 1'b1;
        if (!stall) begin
          if (last) begin
            instr_cnt_d = instr_cnt_q + 1'b1;
            phase_d = '0;
            if (halt_pend_q || halt_req || opcode == HALT_OPC) begin
              state_d = HALT;
              halt_pend_d = 1'b0;
            end
`ifdef SINGLE_STEP_EN
            else if (step_mode) state_d = PAUSE;
`endif
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
`ifdef SINGLE_STEP_EN
      PAUSE: begin
        if (halt_req) state_d = HALT;
        else if (step) begin
          state_d = RUN;
          phase_d = '0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end
endmodule
